// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Purpose  : Serial bit-pattern transmitter. Sends a snapshotted N-bit pattern
//            MSB-first (bit [len-1] first, bit [0] last), one bit per bit_en
//            strobe, repeated 'repeats' times with 'gap' idle bit-times
//            between repetitions. Used as a stimulus source for serial
//            sequence detectors and on-chip self-test.
// Build    : define SEQ_GEN_LFSR_GAP_EN to fill gap bits with an 8-bit
//            Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) instead of 0.
// Ports    : clk, rst_n (async, active-low)
//            start   - begin transmission (only honoured in IDLE)
//            abort   - return to IDLE immediately, no done pulse
//            bit_en  - bit-rate strobe; the bit on x is consumed when high
//            pattern - pattern bits, len - pattern length (1..PAT_W)
//            repeats - repetition count (0 behaves as 1)
//            gap     - gap bit-times between repetitions
//            x, x_valid, busy, done, err - registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_en,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeats,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Snapshot of the transmission parameters, taken when start is accepted.
  logic [PAT_W-1:0] pat_q, pat_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [CNT_W-1:0] rep_q, rep_q_nxt;
  logic [GAP_W-1:0] gap_q, gap_q_nxt;

  // Progress counters: all bounded by the snapshot values above.
  logic [LEN_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

  logic             x_nxt, x_valid_nxt, busy_nxt, done_nxt, err_nxt;
  logic             len_ok;
  logic             gap_bit;
  logic             pat_bit;
  logic [LEN_W-1:0] bit_sel;

  assign len_ok = (len != '0) && (len <= LEN_W'(PAT_W));

  // --------------------------------------------------------------------------
  // Gap bit source
  // --------------------------------------------------------------------------
`ifdef SEQ_GEN_LFSR_GAP_EN
  logic [7:0] lfsr, lfsr_nxt;
  logic       lfsr_adv;

  // The LFSR advances only when a gap bit is actually consumed.
  assign lfsr_adv = (state == ST_GAP) && bit_en && !abort;

  always_comb begin
    lfsr_nxt = lfsr;
    if (lfsr_adv) begin
      lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= lfsr_nxt;
    end
  end

  // x is registered from next-state values, so the gap bit shown next cycle
  // is the MSB of the post-shift LFSR.
  assign gap_bit = lfsr_nxt[7];
`else
  assign gap_bit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      idx     <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pat_q   <= pat_nxt;
      len_q   <= len_nxt;
      rep_q   <= rep_q_nxt;
      gap_q   <= gap_q_nxt;
      idx     <= idx_nxt;
      rep_cnt <= rep_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      x       <= x_nxt;
      x_valid <= x_valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    pat_nxt     = pat_q;
    len_nxt     = len_q;
    rep_q_nxt   = rep_q;
    gap_q_nxt   = gap_q;
    idx_nxt     = idx;
    rep_cnt_nxt = rep_cnt;
    gap_cnt_nxt = gap_cnt;
    err_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        // abort has priority over start, and also suppresses err.
        if (start && !abort) begin
          if (len_ok) begin
            pat_nxt     = pattern;
            len_nxt     = len;
            rep_q_nxt   = (repeats == '0) ? CNT_W'(1) : repeats;
            gap_q_nxt   = gap;
            idx_nxt     = '0;
            rep_cnt_nxt = '0;
            gap_cnt_nxt = '0;
            state_nxt   = ST_SEND;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (bit_en) begin
          if (idx == len_q - LEN_W'(1)) begin
            idx_nxt = '0;
            if (rep_cnt == rep_q - CNT_W'(1)) begin
              state_nxt = ST_DONE;
            end else begin
              rep_cnt_nxt = rep_cnt + CNT_W'(1);
              // With no gap the next repetition starts back-to-back.
              if (gap_q != '0) begin
                gap_cnt_nxt = '0;
                state_nxt   = ST_GAP;
              end
            end
          end else begin
            idx_nxt = idx + LEN_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (bit_en) begin
          if (gap_cnt == gap_q - GAP_W'(1)) begin
            gap_cnt_nxt = '0;
            idx_nxt     = '0;
            state_nxt   = ST_SEND;
          end else begin
            gap_cnt_nxt = gap_cnt + GAP_W'(1);
          end
        end
      end

      ST_DONE: begin
        // Single-cycle state; a start seen here is deliberately dropped.
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: outputs are registered from the next-state values so that
  // the bit on x is the bit consumed by the following bit_en strobe.
  // --------------------------------------------------------------------------
  assign bit_sel = len_nxt - LEN_W'(1) - idx_nxt;

  always_comb begin
    pat_bit = 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (bit_sel == LEN_W'(i)) begin
        pat_bit = pat_nxt[i];
      end
    end
  end

  always_comb begin
    x_nxt       = 1'b0;
    x_valid_nxt = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    case (state_nxt)
      ST_SEND: begin
        x_nxt       = pat_bit;
        x_valid_nxt = 1'b1;
        busy_nxt    = 1'b1;
      end
      ST_GAP: begin
        x_nxt       = gap_bit;
        x_valid_nxt = 1'b1;
        busy_nxt    = 1'b1;
      end
      ST_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        x_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Purpose  : Self-checking bench for seq_pattern_gen. A queue-based model
//            expands each accepted transmission into its full list of
//            pattern/gap bits and is compared against the DUT every cycle;
//            directed sequences pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
  localparam int LEN_W = 4;

`ifdef SEQ_GEN_LFSR_GAP_EN
  localparam logic [15:0] T2_EXP = 16'hBAEB;  // 1011 10 1011 10 1011
`else
  localparam logic [15:0] T2_EXP = 16'hB2CB;  // 1011 00 1011 00 1011
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             bit_en = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [CNT_W-1:0] repeats = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             x, x_valid, busy, done, err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_mode = 0;

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .bit_en (bit_en),
    .pattern(pattern),
    .len    (len),
    .repeats(repeats),
    .gap    (gap),
    .x      (x),
    .x_valid(x_valid),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // --------------------------------------------------------------------------
  // Reference model: a transmission is a queue of {is_gap, bit} entries.
  // --------------------------------------------------------------------------
  logic [1:0] m_q[$];
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;
  logic [7:0] m_lfsr = 8'hA5;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_lfsr   = 8'hA5;
    end else begin
      bit was_done;
      int reps;
      was_done = m_done;
      m_done   = 1'b0;
      m_err    = 1'b0;
      if (m_active) begin
        if (abort) begin
          m_active = 1'b0;
          m_q.delete();
        end else if (bit_en) begin
          if (m_q[0][1]) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end else if (!was_done && start && !abort) begin
        if (len >= 1 && len <= PAT_W) begin
          reps = (repeats == 0) ? 1 : int'(repeats);
          for (int r = 0; r < reps; r++) begin
            for (int i = int'(len) - 1; i >= 0; i--) m_q.push_back({1'b0, pattern[i]});
            if (r < reps - 1) for (int g = 0; g < int'(gap); g++) m_q.push_back(2'b10);
          end
          m_active = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_x();
    if (!m_active) return 1'b0;
`ifdef SEQ_GEN_LFSR_GAP_EN
    if (m_q[0][1]) return m_lfsr[7];
`else
    if (m_q[0][1]) return 1'b0;
`endif
    return m_q[0][0];
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] a;
    e = {exp_x(), m_active, m_active, m_done, m_err};
    a = {x, x_valid, busy, done, err};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t x/valid/busy/done/err got=%b expected=%b", $time, a, e);
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (en_mode)
      0:       bit_en = 1'b1;
      1:       bit_en = (cyc % 3 == 0);
      default: bit_en = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic load(input logic [7:0] p, input int l, input int r, input int g);
    pattern = p;
    len     = LEN_W'(l);
    repeats = CNT_W'(r);
    gap     = GAP_W'(g);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done || m_active || m_done) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout waited=%0d cycles required=idle", n);
    end
  endtask

  task automatic run_t1(input string tag);
    logic [15:0] cap;
    cap = '0;
    load(8'h0B, 4, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cap = {cap[14:0], x};
      step();
    end
    @(negedge clk);
    check({tag, "_bits"}, cap[3:0], 4'b1011);
    check({tag, "_done"}, done, 1'b1);
    step();
  endtask

  task automatic run_t2(input string tag);
    logic [15:0] cap;
    int bcnt;
    cap  = '0;
    bcnt = 0;
    load(8'h0B, 4, 3, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cap  = {cap[14:0], x};
      bcnt += int'(busy);
      step();
    end
    @(negedge clk);
    check({tag, "_bits"}, cap, T2_EXP);
    check({tag, "_busy_cycles"}, bcnt, 16);
    check({tag, "_done"}, done, 1'b1);
    step();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int vcnt;
    en_mode = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single repetition, then three repetitions with a 2-bit gap.
    run_t1("t1");
    wait_idle();
    run_t2("t2");
    wait_idle();

    // Abort at bit index 2 of the first repetition, then a clean restart.
    load(8'h0B, 4, 2, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort_outputs", {x_valid, busy, done}, 3'b000);
    step();
    run_t1("t1_after_abort");
    wait_idle();

    // Illegal lengths raise a one-cycle err and stay idle.
    load(8'hFF, 0, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("err_len0", {err, busy}, 2'b10);
    step();
    @(negedge clk);
    check("err_len0_pulse", err, 1'b0);
    load(8'hFF, 9, 1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("err_len9", {err, busy}, 2'b10);
    step();

    // repeats=0 sends exactly one repetition.
    load(8'h0B, 4, 0, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) break;
      vcnt += int'(x_valid);
      step();
    end
    check("rep0_valid_cycles", vcnt, 4);
    wait_idle();

    // Every third cycle strobed: model checks each bit is held.
    en_mode = 1;
    load(8'hA6, 8, 2, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
    en_mode = 0;
    step();

    // Asynchronous reset in the middle of a gap.
    load(8'h02, 2, 2, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", {x, x_valid, busy, done, err}, 5'b00000);
    step();
    step();
    rst_n = 1'b1;
    step();
    run_t2("t2_after_rst");
    wait_idle();

    // Randomized traffic: start during busy, aborts, resets, varying strobes.
    en_mode = 2;
    for (int it = 0; it < 4000; it++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 63) == 0);
      pattern = PAT_W'($urandom);
      len     = LEN_W'($urandom_range(0, 10));
      repeats = CNT_W'($urandom_range(0, 3));
      gap     = GAP_W'($urandom_range(0, 3));
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_async_rst", {x, x_valid, busy, done, err}, 5'b00000);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    en_mode = 0;
    step();
    wait_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
